// File: rtl/quad_pkg.sv
`default_nettype none
//==============================================================================
// Package  : quad_pkg
// Desc     : Shared constants, quadrature state encoding and step decoder.
// Revision : 1.0
//==============================================================================
package quad_pkg;

  localparam int ERR_CNT_WIDTH  = 8;
  localparam int FILT_CNT_WIDTH = 4;

  // Encoder state is {A,B}
  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;
  localparam logic [1:0] ST_01 = 2'b01;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_ILL  = 2'd3
  } step_t;

  function automatic logic [1:0] next_fwd(input logic [1:0] st);
    logic [1:0] nxt;
    nxt = ST_00;
    case (st)
      ST_00:   nxt = ST_10;
      ST_10:   nxt = ST_11;
      ST_11:   nxt = ST_01;
      default: nxt = ST_00;
    endcase
    return nxt;
  endfunction

  function automatic step_t step_decode(input logic [1:0] prev, input logic [1:0] cur);
    step_t step;
    step = STEP_ILL;
    if (cur == prev)
      step = STEP_NONE;
    else if (cur == next_fwd(prev))
      step = STEP_INC;
    else if (prev == next_fwd(cur))
      step = STEP_DEC;
    return step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_filter.sv
`default_nettype none
//==============================================================================
// Module   : quad_filter
// Desc     : 2-flop synchronizer followed by a run-length deglitch filter.
// Revision : 1.0
//==============================================================================
module quad_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic filt_out
);

  localparam logic [FILT_CNT_WIDTH-1:0] c_run_last = FILT_CNT_WIDTH'(FILTER_LEN - 1);
  localparam logic [FILT_CNT_WIDTH-1:0] c_run_one  = FILT_CNT_WIDTH'(1);

  logic [1:0]                r_sync;
  logic [FILT_CNT_WIDTH-1:0] r_run;
  logic                      r_filt;

  // The output only moves after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_run  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw_in};
      if (r_sync[1] == r_filt) begin
        r_run <= '0;
      end else if (r_run == c_run_last) begin
        r_filt <= r_sync[1];
        r_run  <= '0;
      end else begin
        r_run <= r_run + c_run_one;
      end
    end
  end

  assign filt_out = r_filt;

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
//==============================================================================
// Module   : quad_decoder
// Desc     : Quadrature encoder front end: deglitch, Gray decode, signed count,
//            illegal-transition flagging and optional periodic velocity.
// Options  : QUAD_VELOCITY_EN - compiles in the period counter and velocity.
// Revision : 1.0
//==============================================================================
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int VEL_PERIOD  = 500_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enc_a,
  input  logic                     enc_b,
  input  logic                     clear,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic [COUNT_WIDTH-1:0]   velocity,
  output logic                     vel_valid,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  localparam int                       c_prime_w  = 5;
  localparam logic [c_prime_w-1:0]     c_prime_at = c_prime_w'(FILTER_LEN + 2);
  localparam logic [c_prime_w-1:0]     c_prime_1  = c_prime_w'(1);
  localparam logic [COUNT_WIDTH-1:0]   c_cnt_one  = COUNT_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] c_err_one  = ERR_CNT_WIDTH'(1);

  generate
    if (FILTER_LEN < 1 || FILTER_LEN > 15 || VEL_PERIOD < 2) begin : g_param_check
      $error("quad_decoder: FILTER_LEN or VEL_PERIOD out of range");
    end
  endgenerate

  logic [1:0] w_raw;
  logic [1:0] w_cur;

  assign w_raw = {enc_a, enc_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
      quad_filter #(
        .FILTER_LEN (FILTER_LEN)
      ) u_filt (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (w_raw[gi]),
        .filt_out (w_cur[gi])
      );
    end
  endgenerate

  logic [c_prime_w-1:0] r_prime_cnt;
  logic                 r_primed;
  logic [1:0]           r_prev;
  step_t                w_step;

  // Prime samples the filter once its reset-time latency has elapsed, so the
  // pin levels present at reset release are never decoded as a step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prime_cnt <= '0;
      r_primed    <= 1'b0;
      r_prev      <= ST_00;
    end else if (!r_primed) begin
      if (r_prime_cnt == c_prime_at) begin
        r_prev   <= w_cur;
        r_primed <= 1'b1;
      end else begin
        r_prime_cnt <= r_prime_cnt + c_prime_1;
      end
    end else begin
      r_prev <= w_cur;
    end
  end

  assign w_step = r_primed ? step_decode(r_prev, w_cur) : STEP_NONE;

  logic [COUNT_WIDTH-1:0]   r_count;
  logic                     r_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= (w_step == STEP_ILL);
      if (w_step == STEP_ILL && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + c_err_one;
      // clear overrides any step decoded in the same cycle
      if (clear)
        r_count <= '0;
      else if (w_step == STEP_INC)
        r_count <= r_count + c_cnt_one;
      else if (w_step == STEP_DEC)
        r_count <= r_count - c_cnt_one;
    end
  end

  assign count   = r_count;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

`ifdef QUAD_VELOCITY_EN
  localparam int                   c_per_w    = $clog2(VEL_PERIOD);
  localparam logic [c_per_w-1:0]   c_per_last = c_per_w'(VEL_PERIOD - 1);
  localparam logic [c_per_w-1:0]   c_per_one  = c_per_w'(1);

  logic [c_per_w-1:0]     r_period;
  logic [COUNT_WIDTH-1:0] r_snapshot;
  logic [COUNT_WIDTH-1:0] r_velocity;
  logic                   r_vel_valid;
  logic                   w_per_tc;

  assign w_per_tc = (r_period == c_per_last);

  // Velocity uses the registered count, so a step decoded at terminal count
  // is attributed to the following period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period    <= '0;
      r_snapshot  <= '0;
      r_velocity  <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_vel_valid <= w_per_tc;
      if (w_per_tc) begin
        r_period   <= '0;
        r_velocity <= r_count - r_snapshot;
      end else begin
        r_period <= r_period + c_per_one;
      end
      if (clear)
        r_snapshot <= '0;
      else if (w_per_tc)
        r_snapshot <= r_count;
    end
  end

  assign velocity  = r_velocity;
  assign vel_valid = r_vel_valid;
`else
  assign velocity  = '0;
  assign vel_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// Directed bench for quad_decoder: vector table plus hand-timed sequences.
module tb_quad_decoder;

  localparam int FL = 4;
  localparam int CW = 16;
  localparam int VP = 1000;
  localparam int NV = 42;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enc_a = 1'b0;
  logic          enc_b = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] count;
  logic [CW-1:0] velocity;
  logic          vel_valid;
  logic          err;
  logic [7:0]    err_cnt;

  logic          wa = 1'b0;
  logic          wb = 1'b0;
  logic          wclear = 1'b0;
  logic [CW-1:0] wcount;
  logic [CW-1:0] wvel;
  logic          wvv;
  logic          werr;
  logic [7:0]    werr_cnt;

  quad_decoder #(.FILTER_LEN(FL), .COUNT_WIDTH(CW), .VEL_PERIOD(VP)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .count(count), .velocity(velocity), .vel_valid(vel_valid),
    .err(err), .err_cnt(err_cnt)
  );

  // Fast instance used only to reach the signed wrap point quickly
  quad_decoder #(.FILTER_LEN(1), .COUNT_WIDTH(CW), .VEL_PERIOD(VP)) dut_wrap (
    .clk(clk), .reset(reset), .enc_a(wa), .enc_b(wb), .clear(wclear),
    .count(wcount), .velocity(wvel), .vel_valid(wvv),
    .err(werr), .err_cnt(werr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    st;
    logic          clr;
    int            hold;
    logic [CW-1:0] exp_count;
    logic [7:0]    exp_err_cnt;
  } vec_t;

  vec_t       vecs [NV];
  logic [1:0] fwd [4];
  logic [1:0] bwd [4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int err_pulses = 0;
  int werr_pulses = 0;
  int vel_n = 0;
  int vel_cyc [2];
  logic [CW-1:0] vel_val [2];
  int e0;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (werr === 1'b1) werr_pulses++;
    if (vel_valid === 1'b1) begin
      if (vel_n < 2) begin
        vel_cyc[vel_n] = cyc;
        vel_val[vel_n] = velocity;
      end
      vel_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] st, input logic clr, input int hold,
                              input logic [CW-1:0] c);
    vec_t v;
    v.st = st;
    v.clr = clr;
    v.hold = hold;
    v.exp_count = c;
    v.exp_err_cnt = 8'd0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd[0] = 2'b00; fwd[1] = 2'b10; fwd[2] = 2'b11; fwd[3] = 2'b01;
    bwd[0] = 2'b00; bwd[1] = 2'b01; bwd[2] = 2'b11; bwd[3] = 2'b10;
    vel_cyc[0] = 0; vel_cyc[1] = 0;

    // Forward steps 2..40 starting from state 01 (step 1 done by hand)
    for (int k = 2; k <= 40; k++)
      vecs[k-2] = mk(fwd[(3 + k) % 4], 1'b0, 20, 16'(k));
    vecs[39] = mk(2'b01, 1'b1, 20, 16'h0000);
    vecs[40] = mk(2'b11, 1'b0, 20, 16'hFFFF);
    vecs[41] = mk(2'b01, 1'b0, 20, 16'h0000);

    // Reset state
    tick(5);
    check("rst_count", count, 0);
    check("rst_velocity", velocity, 0);
    check("rst_vel_valid", vel_valid, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset = 1'b0;
    tick(20);

    // 25 backward steps inside the first velocity period
    for (int k = 1; k <= 25; k++) begin
      {enc_a, enc_b} = bwd[k % 4];
      tick(20);
    end
    check("bwd_count", count, 16'hFFE7);
    tick(2010 - cyc);
`ifdef QUAD_VELOCITY_EN
    check("vel_pulses", vel_n, 2);
    check("vel0_cycle", vel_cyc[0], 1000);
    check("vel0_value", vel_val[0], 16'hFFE7);
    check("vel1_cycle", vel_cyc[1], 2000);
    check("vel1_value", vel_val[1], 16'h0000);
`else
    check("vel_pulses_off", vel_n, 0);
    check("velocity_off", velocity, 0);
`endif

    // clear with one-cycle latency
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_count", count, 0);

    // First forward step latency: 01 -> 00 lands 7 cycles after the pin edge
    e0 = err_pulses;
    {enc_a, enc_b} = 2'b00;
    tick(6);
    check("fwd_latency_6", count, 0);
    tick(1);
    check("fwd_latency_7", count, 1);
    tick(13);

    for (int i = 0; i < NV; i++) begin
      {enc_a, enc_b} = vecs[i].st;
      clear = vecs[i].clr;
      tick(1);
      clear = 1'b0;
      tick(vecs[i].hold - 1);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      check($sformatf("vec%0d_err_cnt", i), err_cnt, vecs[i].exp_err_cnt);
    end
    check("fwd_err_pulses", err_pulses - e0, 0);

    // clear in the same cycle as a decoded step
    {enc_a, enc_b} = 2'b00;
    tick(20);
    check("pre_clear_count", count, 1);
    {enc_a, enc_b} = 2'b10;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clear_vs_step", count, 0);
    tick(13);
    check("clear_step_lost", count, 0);

    // Glitch rejection on B from state 10
    e0 = err_pulses;
    enc_b = 1'b1;
    tick(3);
    enc_b = 1'b0;
    tick(20);
    check("glitch3_count", count, 0);
    check("glitch3_err", err_pulses - e0, 0);
    enc_b = 1'b1;
    tick(4);
    enc_b = 1'b0;
    tick(3);
    check("glitch4_plus", count, 1);
    tick(4);
    check("glitch4_minus", count, 0);
    tick(20);
    check("glitch4_err", err_pulses - e0, 0);

    // Illegal transitions 10 <-> 01, saturation of err_cnt
    e0 = err_pulses;
    {enc_a, enc_b} = 2'b01;
    tick(6);
    check("ill_err_early", err, 0);
    tick(1);
    check("ill_err_pulse", err, 1);
    check("ill_err_cnt1", err_cnt, 1);
    tick(1);
    check("ill_err_drop", err, 0);
    tick(12);
    check("ill_count", count, 0);
    check("ill_pulses1", err_pulses - e0, 1);
    for (int i = 0; i < 299; i++) begin
      {enc_a, enc_b} = (i % 2 == 0) ? 2'b10 : 2'b01;
      tick(10);
    end
    tick(10);
    check("ill_err_cnt_sat", err_cnt, 255);
    check("ill_pulses300", err_pulses - e0, 300);
    check("ill_count_end", count, 0);

    // Signed wrap on the fast instance
    for (int i = 1; i <= 32767; i++) begin
      {wa, wb} = fwd[i % 4];
      tick(1);
    end
    tick(10);
    check("wrap_7fff", wcount, 16'h7FFF);
    {wa, wb} = fwd[0];
    tick(10);
    check("wrap_8000", wcount, 16'h8000);
    check("wrap_err", werr_pulses, 0);

    // Reset mid-rotation with pins at 11, then prime and step
    {enc_a, enc_b} = 2'b11;
    tick(20);
    check("pre_reset_count", count, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_velocity", velocity, 0);
    check("mid_rst_vel_valid", vel_valid, 0);
    check("mid_rst_err", err, 0);
    tick(3);
    reset = 1'b0;
    e0 = err_pulses;
    tick(30);
    check("prime_err", err_pulses - e0, 0);
    check("prime_count", count, 0);
    check("prime_err_cnt", err_cnt, 0);
    {enc_a, enc_b} = 2'b01;
    tick(20);
    check("post_prime_step", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quad_decoder.md
# quad_decoder

Single-channel quadrature encoder front end sitting directly between the board-level `quad_enc_a`/`quad_enc_b` pins and the hba_quad register peripheral. Instantiated once per wheel (index 0 left, index 1 right). It synchronizes and deglitches the raw A/B inputs, decodes Gray-code transitions into a signed position count, flags illegal transitions, and optionally produces a periodic velocity sample. hba_quad only reads these outputs and pulses `clear`.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronized samples required before a filtered input changes; legal range 1..15.
- `COUNT_WIDTH`, 16: width of `count` and `velocity`, two's complement.
- `VEL_PERIOD`, 500_000: clk cycles per velocity sample, i.e. 10 ms at 50 MHz; legal range ≥ 2.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enc_a` in 1: raw encoder A, asynchronous to clk.
- `enc_b` in 1: raw encoder B, asynchronous to clk.
- `clear` in 1: synchronous one-cycle pulse; zeroes `count` and the velocity snapshot.
- `count` out COUNT_WIDTH: signed position. Reset value 0.
- `velocity` out COUNT_WIDTH: signed count delta over the last period. Reset value 0.
- `vel_valid` out 1: one-cycle pulse when `velocity` updates. Reset value 0.
- `err` out 1: one-cycle pulse on an illegal transition. Reset value 0.
- `err_cnt` out 8: saturating count of illegal transitions. Cleared only by reset. Reset value 0.

## Operation
- **Synchronizer:** 2 flops per input, reset to 0.
- **Filter, per input:**
  - Run counter increments while the synchronized value differs from the filtered value, and returns to 0 on any match.
  - When the run counter is FILTER_LEN-1 and the synchronized value still differs, the filtered value takes the new value and the counter returns to 0.
  - A pulse shorter than FILTER_LEN cycles never propagates.
- **Prime:**
  - After reset, the first filter output is loaded into `prev` without decoding. The prime happens FILTER_LEN+2 cycles after reset deassert.
  - No count change and no `err` at prime, whatever the pin levels.
- **Decode:** state is {A,B}. Compare the current filtered state with `prev` every cycle.
  - Increment sequence: 00→10→11→01→00. Each step is +1.
  - Decrement sequence: the reverse. Each step is −1.
  - No change: hold.
  - Both bits changed: illegal. Pulse `err`, increment `err_cnt` (saturating at 255), leave `count` unchanged, and update `prev` to the new state.
- **Count arithmetic:** modulo 2^COUNT_WIDTH. 0x7FFF+1 → 0x8000. 0x0000−1 → 0xFFFF.
- **clear:**
  - `count` is 0 on the next edge.
  - If a step decodes in the same cycle, `clear` wins and that step is lost.
  - The velocity snapshot is also set to 0.
- **Velocity:**
  - A period counter runs 0..VEL_PERIOD-1 and starts at 0 on reset.
  - At terminal count: `velocity` ← `count` − `snapshot` (modulo), `snapshot` ← `count`, `vel_valid` pulses.
  - The `count` used here is the registered value of that cycle. A step decoded in the same cycle lands in the next period.
- **Reset mid-operation:** all of the above return to their reset values immediately. The next prime is taken afresh.

## Timing
- Pin change to `count` change: FILTER_LEN+3 cycles (7 with defaults). Breakdown: 2 sync cycles + FILTER_LEN filter cycles + 1 decode register.
- `err` asserts in the same cycle `count` would have changed.
- Maximum sustained step rate: one filtered change per FILTER_LEN cycles per input. Faster edges are filtered out, never miscounted as illegal.
- `vel_valid` first pulses VEL_PERIOD cycles after reset deassert, then every VEL_PERIOD cycles.
- `clear` has 1-cycle latency and no handshake.

## Configuration
- `QUAD_VELOCITY_EN` defined: period counter, snapshot and `velocity`/`vel_valid` logic are compiled in as described above.
- `QUAD_VELOCITY_EN` undefined: none of that logic exists. `velocity` is tied to 0 and `vel_valid` to 0. Counting and error behaviour are unchanged.

## Structure
- Shared package `quad_pkg` holds:
  - the state encoding constants (ST_00, ST_10, ST_11, ST_01);
  - the step decode function (prev, cur → +1 / −1 / 0 / illegal);
  - the `err_cnt` width.
- Sub-module `quad_filter` (2-flop synchronizer plus run-length filter, parameter FILTER_LEN) is instantiated twice, once for A and once for B. Decode, count and velocity logic stay in `quad_decoder`.

## Test plan
- **Forward rotation:** after reset with pins 00, apply 40 forward steps (A leads B), each level held 20 cycles. Required: `count`=40, `err_cnt`=0, first change 7 cycles after the first pin edge.
- **Glitch rejection:** apply a 3-cycle pulse on A with FILTER_LEN=4. Required: `count` unchanged, no `err`. Then apply a 4-cycle pulse. Required: +1 then −1, net `count`=0.
- **Illegal transition and saturation:** drive pins 00→11 in one edge. Required: one `err` pulse, `count` unchanged, `err_cnt`=1. Repeat 300 times. Required: `err_cnt`=255.
- **Wrap and clear:** reach `count`=0x7FFF, then step +1. Required: `count`=0x8000. Pulse `clear` in the same cycle as a decoded step. Required: `count`=0.
- **Velocity (with QUAD_VELOCITY_EN, VEL_PERIOD=1000):** apply 25 backward steps inside one period. Required: `vel_valid` at cycle 1000 and `velocity`=0xFFE7 (−25). The next idle period yields `velocity`=0.
- **Reset mid-count and prime:** hold pins at 11, assert `reset` mid-rotation, release. Required: all outputs 0, prime with no `err`, and a subsequent forward step gives `count`=1.
